// File: rtl/lsu_mem_initiator_pkg.sv
// Shared encodings and FSM states for the load/store initiator.
// Size codes equal the data_memory maskmode codes, so MASK_WORD is SIZE_W.
package lsu_mem_initiator_pkg;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_X    = 2'b11;
  localparam logic [1:0] MASK_WORD = SIZE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Illegal size, or a half/word whose address is not naturally aligned.
  function automatic logic is_bad_access(logic [1:0] size, logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane alignment: extracts and extends a sub-word load from a memory word,
// and merges right-aligned store data into the addressed lane of a word.
module lsu_lane_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [31:0] data,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = data[{addr_lo, 3'b000} +: 8];
  assign half_lane = data[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value held (which would infer a latch).
  always_comb begin
    rdata_ext = '0;
    merged    = data;
    case (size)
      SIZE_B: begin
        rdata_ext = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        rdata_ext = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_W: begin
        rdata_ext = data;
        merged    = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, word-mode memory accesses,
// sub-word stores done as read-modify-write, misaligned requests flagged.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q;
  logic [DATA_WIDTH-1:0] rdata_ext, merged;
  logic                  accept, bad_req;

  assign accept  = req_valid && req_ready;
  assign bad_req = is_bad_access(req_size, req_addr[1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= bad_req;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_RD) data_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_req)              state_d = ST_RESP;
          else if (!req_we)         state_d = ST_RD;
          else if (req_size == SIZE_W) state_d = ST_WR;
          else                      state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .data        (data_q),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata_ext   (rdata_ext),
    .merged      (merged)
  );

  // Memory strobes come straight from the state register, so an async reset
  // withdraws them in the same instant.
  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_err      = rsp_valid && err_q;
  assign rsp_rdata    = (rsp_valid && !we_q && !err_q) ? rdata_ext : '0;
  assign mem_read     = (state_q == ST_RD);
  assign mem_write    = (state_q == ST_WR);
  assign mem_maskmode = MASK_WORD;
  assign mem_sext     = 1'b0;
  assign mem_address  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata    = mem_write ? merged : '0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a small word-mode memory model;
// the driver queues expectations at accept, the monitor checks each response.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  lsu_mem_initiator dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_maskmode (mem_maskmode),
    .mem_sext     (mem_sext),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-mode data memory: combinational read, commit on negedge.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_address[5:2]];
  always @(negedge clk) if (mem_write) mem[mem_address[5:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts memory strobes per transaction, checks each response.
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read)  begin rd_cnt++; last_addr = mem_address; end
      if (mem_write) begin wr_cnt++; last_addr = mem_address; last_wdata = mem_wdata; end
      if (rsp_valid) begin
        n_rsp++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%08h, expected none", rsp_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
          check("mem_read_cycles", 32'(rd_cnt), 32'(e.rd));
          check("mem_write_cycles", 32'(wr_cnt), 32'(e.wr));
          check("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (e.rd + e.wr > 0) check("mem_address", last_addr, e.addr);
          if (e.wr > 0) check("mem_wdata", last_wdata, e.wdata);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Presents a request (leaving req_valid high) and waits for acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                       input int e_rd, input int e_wr, input logic [31:0] e_wdata,
                       input logic push);
    exp_t e;
    int   waited;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h, expected 1", addr);
      return;
    end
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.rd = e_rd; e.wr = e_wr;
    e.addr = {addr[31:2], 2'b00}; e.wdata = e_wdata; e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic wait_done();
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  int rsp_before;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h8844_2211;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("mem_maskmode", 32'(mem_maskmode), 32'h2);
    check("mem_sext", 32'(mem_sext), 32'h0);
    reset = 1'b0;

    // Loads: byte signed, half unsigned, word, half signed, byte unsigned
    issue(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FF88, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_8844, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8844_2211, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8844, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_0088, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(0, 2'b00, 0, 32'h11, 32'h0, 32'h0000_0022, 0, 2, 1, 0, 32'h0, 1); wait_done();

    // Stores: sub-word RMW, word store, re-reads
    issue(1, 2'b00, 0, 32'h11, 32'h0000_00AB, 32'h0, 0, 3, 1, 1, 32'h8844_AB11, 1); wait_done();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8844_AB11, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(1, 2'b10, 0, 32'h14, 32'h1234_5678, 32'h0, 0, 2, 0, 1, 32'h1234_5678, 1); wait_done();
    issue(1, 2'b01, 0, 32'h16, 32'h0000_BEEF, 32'h0, 0, 3, 1, 1, 32'hBEEF_5678, 1); wait_done();
    issue(0, 2'b10, 0, 32'h14, 32'h0, 32'hBEEF_5678, 0, 2, 1, 0, 32'h0, 1); wait_done();
    issue(1, 2'b00, 0, 32'h10, 32'hFFFF_FFCD, 32'h0, 0, 3, 1, 1, 32'h8844_ABCD, 1); wait_done();

    // Errors: misaligned half, misaligned word store, illegal size
    issue(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1); wait_done();
    issue(1, 2'b10, 0, 32'h12, 32'hDEAD_BEEF, 32'h0, 1, 1, 0, 0, 32'h0, 1); wait_done();
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1); wait_done();
    check("err_no_write", mem[4], 32'h8844_ABCD);

    // Reset raised during the write cycle of a half store
    issue(1, 2'b01, 0, 32'h10, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    check("mem_write_in_wr", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mem_write_drops", 32'(mem_write), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("word_unchanged", mem[4], 32'h8844_ABCD);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8844_ABCD, 0, 2, 1, 0, 32'h0, 1); wait_done();

    // Back-to-back loads with req_valid held high throughout
    rsp_before = n_rsp;
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8844_ABCD, 0, 2, 1, 0, 32'h0, 1);
    issue(0, 2'b00, 0, 32'h12, 32'h0, 32'h0000_0044, 0, 2, 1, 0, 32'h0, 1);
    issue(0, 2'b01, 1, 32'h16, 32'h0, 32'h0000_BEEF, 0, 2, 1, 0, 32'h0, 1);
    wait_done();
    repeat (4) @(negedge clk);
    check("held_valid_rsp_count", 32'(n_rsp - rsp_before), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
